// File: rtl/sprite_blitter_if.sv
// sprite_blitter_if
//   Request / pixel-stream bundle between the game control FSM, the sprite
//   blitter and the vga_adapter plot port.
//   master : requester side (drives start/erase/tile/shape/colour and ready,
//            observes the pixel stream and status)
//   slave  : blitter side
//   Request : start, erase, x_tile, y_tile, shape, colour
//   Stream  : plot (valid), ready, x_out, y_out, col_out
//   Status  : busy, done
interface sprite_blitter_if #(
  parameter int SPRITE_W = 5,
  parameter int SPRITE_H = 5,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COL_W    = 3
);
  logic                         start;
  logic                         erase;
  logic [X_W-1:0]               x_tile;
  logic [Y_W-1:0]               y_tile;
  logic [SPRITE_W*SPRITE_H-1:0] shape;
  logic [COL_W-1:0]             colour;
  logic                         ready;
  logic                         plot;
  logic [X_W-1:0]               x_out;
  logic [Y_W-1:0]               y_out;
  logic [COL_W-1:0]             col_out;
  logic                         busy;
  logic                         done;

  modport master (
    output start, erase, x_tile, y_tile, shape, colour, ready,
    input  plot, x_out, y_out, col_out, busy, done
  );

  modport slave (
    input  start, erase, x_tile, y_tile, shape, colour, ready,
    output plot, x_out, y_out, col_out, busy, done
  );
endinterface

// File: rtl/sprite_blitter.sv
// sprite_blitter
//   Tile-sprite renderer. A start request latches a tile coordinate, a
//   SPRITE_W x SPRITE_H bitmap (MSB = top-left, row-major) and a colour, then
//   streams one pixel per accepted cycle in raster order to the VGA plot port,
//   followed by a one-cycle done pulse.
//
// Ports
//   clock    : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : sprite_blitter_if.slave (request, pixel stream, busy/done)
//
// Build option
//   SPRITE_BLITTER_TRANSPARENT_EN : when defined, 0 bits in draw mode are
//   skipped (plot=0, one cycle, no ready wait) so the background under the
//   sprite is left untouched. Erase mode always plots every pixel.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; outputs hold the last pixel drawn
// DRAW   | presenting pixel (col,row); advances on plot && ready
// DONE   | one-cycle done pulse after the last pixel, then IDLE
module sprite_blitter #(
  parameter int SPRITE_W  = 5,
  parameter int SPRITE_H  = 5,
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int COL_W     = 3,
  parameter int BG_COLOUR = 0
) (
  input logic           clock,
  input logic           reset_n,
  sprite_blitter_if.slave bus
);

  localparam int N  = SPRITE_W * SPRITE_H;
  localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam logic [COL_W-1:0] BG = COL_W'(BG_COLOUR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q,   state_d;
  logic             erase_q,   erase_d;
  logic [N-1:0]     shape_q,   shape_d;
  logic [COL_W-1:0] colour_q,  colour_d;
  logic [X_W-1:0]   xbase_q,   xbase_d;
  logic [Y_W-1:0]   ybase_q,   ybase_d;
  logic [CW-1:0]    col_q,     col_d;
  logic [RW-1:0]    row_q,     row_d;
  logic             plot_q,    plot_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic [X_W-1:0]   x_out_q,   x_out_d;
  logic [Y_W-1:0]   y_out_q,   y_out_d;
  logic [COL_W-1:0] col_out_q, col_out_d;

  // Raster position after the current one.
  logic          col_wrap;
  logic          last_pix;
  logic [CW-1:0] col_n;
  logic [RW-1:0] row_n;

  always_comb begin
    col_wrap = (col_q == CW'(SPRITE_W - 1));
    last_pix = col_wrap && (row_q == RW'(SPRITE_H - 1));
    col_n    = col_wrap ? '0 : col_q + 1'b1;
    row_n    = col_wrap ? row_q + 1'b1 : row_q;
  end

  // Pixel about to be presented: the first pixel of a new request while in
  // IDLE, otherwise the next raster position of the latched sprite.
  logic [N-1:0]     probe_shape;
  logic [N-1:0]     probe_bits;
  logic             probe_erase;
  logic [COL_W-1:0] probe_fg;
  logic [CW-1:0]    probe_col;
  logic [RW-1:0]    probe_row;
  logic             probe_bit;
  logic [COL_W-1:0] probe_colour;
  logic             probe_plot;
  logic [X_W-1:0]   xbase_new;
  logic [Y_W-1:0]   ybase_new;

  always_comb begin
    xbase_new   = X_W'(int'(bus.x_tile) * SPRITE_W);
    ybase_new   = Y_W'(int'(bus.y_tile) * SPRITE_H);
    probe_shape = shape_q;
    probe_erase = erase_q;
    probe_fg    = colour_q;
    probe_col   = col_n;
    probe_row   = row_n;
    if (state_q == S_IDLE) begin
      probe_shape = bus.shape;
      probe_erase = bus.erase;
      probe_fg    = bus.colour;
      probe_col   = '0;
      probe_row   = '0;
    end
    // Shift the addressed bit up to the MSB instead of indexing from the top.
    probe_bits   = probe_shape << (int'(probe_row) * SPRITE_W + int'(probe_col));
    probe_bit    = probe_bits[N-1];
    probe_colour = (probe_erase || !probe_bit) ? BG : probe_fg;
`ifdef SPRITE_BLITTER_TRANSPARENT_EN
    probe_plot   = probe_erase || probe_bit;
`else
    probe_plot   = 1'b1;
`endif
  end

  // A presented pixel moves on when accepted; a skipped (plot=0) position in
  // DRAW moves on unconditionally.
  logic advance;

  always_comb begin
`ifdef SPRITE_BLITTER_TRANSPARENT_EN
    advance = plot_q ? bus.ready : 1'b1;
`else
    advance = bus.ready;
`endif
  end

  always_comb begin
    state_d   = state_q;
    erase_d   = erase_q;
    shape_d   = shape_q;
    colour_d  = colour_q;
    xbase_d   = xbase_q;
    ybase_d   = ybase_q;
    col_d     = col_q;
    row_d     = row_q;
    plot_d    = plot_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    x_out_d   = x_out_q;
    y_out_d   = y_out_q;
    col_out_d = col_out_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          erase_d   = bus.erase;
          shape_d   = bus.shape;
          colour_d  = bus.colour;
          xbase_d   = xbase_new;
          ybase_d   = ybase_new;
          col_d     = '0;
          row_d     = '0;
          x_out_d   = xbase_new;
          y_out_d   = ybase_new;
          col_out_d = probe_colour;
          plot_d    = probe_plot;
          busy_d    = 1'b1;
          state_d   = S_DRAW;
        end
      end

      S_DRAW: begin
        if (advance) begin
          if (last_pix) begin
            plot_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            col_d     = col_n;
            row_d     = row_n;
            x_out_d   = xbase_q + X_W'(col_n);
            y_out_d   = ybase_q + Y_W'(row_n);
            col_out_d = probe_colour;
            plot_d    = probe_plot;
          end
        end
      end

      S_DONE: begin
        plot_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        plot_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      erase_q   <= 1'b0;
      shape_q   <= '0;
      colour_q  <= '0;
      xbase_q   <= '0;
      ybase_q   <= '0;
      col_q     <= '0;
      row_q     <= '0;
      plot_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      x_out_q   <= '0;
      y_out_q   <= '0;
      col_out_q <= '0;
    end else begin
      state_q   <= state_d;
      erase_q   <= erase_d;
      shape_q   <= shape_d;
      colour_q  <= colour_d;
      xbase_q   <= xbase_d;
      ybase_q   <= ybase_d;
      col_q     <= col_d;
      row_q     <= row_d;
      plot_q    <= plot_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      x_out_q   <= x_out_d;
      y_out_q   <= y_out_d;
      col_out_q <= col_out_d;
    end
  end

  assign bus.plot    = plot_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.x_out   = x_out_q;
  assign bus.y_out   = y_out_q;
  assign bus.col_out = col_out_q;

endmodule
